vga_fb_arbiter: RTL and testbench
=================================

# vga_fb_arbiter

Shares one single-port synchronous frame-buffer RAM between VGA scan-out reads and two writers: a host pixel-write port and an internal fill (clear-screen) engine. It sits between the VGA timer (h/v counters, syncs, display enable) and the colour output stage, replacing fixed-pattern bit generation with a 160x120, 3-bit-per-pixel buffer. Each buffer pixel covers a 4x4 block of screen pixels. Scan-out reads have absolute priority, and the syncs are delayed to match the read pipeline.

## Interface
- FB_W, 160, frame-buffer width in pixels; fb_x = h_counter[9:2]
- FB_H, 120, frame-buffer height in pixels; fb_y = v_counter[8:2]
- ADDR_W, 15, RAM address width; address = fb_y*FB_W + fb_x
- clk  in  1  system clock (50 MHz); all logic on rising edge
- clear  in  1  reset, asynchronous, active-low
- pix_en  in  1  one-cycle strobe per VGA pixel; h/v/sync inputs valid in that cycle
- h_counter, v_counter  in  10 each  timer counters
- hsync_in, vsync_in, bright_in  in  1 each  timer syncs and display enable
- hsync, vsync, bright  out  1 each  syncs and enable delayed to align with rgb
- rgb  out  3  pixel colour {R,G,B}; 0 whenever bright is low
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  3  RAM write data
- mem_rdata  in  3  RAM read data, valid one clk after the address is presented
- wr_valid, wr_ready  in/out  1 each  host write handshake
- wr_x  in  8  host write x coordinate
- wr_y  in  7  host write y coordinate
- wr_rgb  in  3  host write colour
- fill_start  in  1  fill request pulse
- fill_rgb  in  3  fill colour
- fill_busy  out  1  fill engine active
- fill_done  out  1  one-cycle pulse when fill completes

## Operation
- Display slot: when pix_en && bright_in && h_counter[1:0]==0 in cycle T, register disp_req_q=1 and disp_addr from the counters. In T+1, mem_addr=disp_addr and mem_we=0. In T+2, capture mem_rdata into pix_q.
- pix_q holds its value between slots, so each buffer pixel covers 4 screen pixels.
- rgb = bright ? pix_q : 0.
- Sync pipeline: hsync_in, vsync_in and bright_in are each delayed through 3 clk registers, loaded every clk regardless of pix_en, to give hsync, vsync and bright.
- Arbitration per cycle, in priority order:
  - disp_req_q: display read.
  - fill_busy: fill write.
  - wr_valid && wr_ready: host write.
  - otherwise: mem_we=0 and mem_addr holds its previous value.
- wr_ready = clear && !disp_req_q && !fill_busy (combinational).
- A write is accepted on wr_valid && wr_ready and is performed in that same cycle.
- Out-of-range host coordinates (wr_x>=FB_W or wr_y>=FB_H) are accepted but dropped: mem_we=0.
- Fill FSM:
  - States are IDLE and FILL.
  - IDLE -> FILL on fill_start: load fill_cnt=0 and latch fill_rgb.
  - In FILL, each non-display cycle writes address fill_cnt and then increments fill_cnt.
  - After the write to FB_W*FB_H-1 (19199): go to IDLE and pulse fill_done in the next cycle.
  - fill_start while in FILL is ignored, and the fill colour does not change.
- Address arithmetic: y*160 is computed as (y<<7)+(y<<5), giving a 15-bit result. Maximum address 19199 fits without overflow.
- Reset values (clear low): state IDLE, fill_cnt 0, disp_req_q 0, pix_q 0, all delay registers 0, mem_addr 0, mem_we 0, mem_wdata 0, rgb 0, hsync/vsync/bright 0, fill_busy 0, fill_done 0, wr_ready 0.
- Reset asserted mid-fill abandons the fill: no fill_done pulse, and the RAM contents are undefined.

## Timing
- Display latency: pix_en in cycle T gives the new rgb visible from T+3. The sync/bright delay is also 3 clk.
- A display slot costs exactly one RAM cycle (T+1). wr_ready is low only in that cycle.
- Host write throughput: 1 per clk outside display slots and fills.
- Fill duration: 19200 + (number of display slots during the fill) clk. fill_busy rises the cycle after fill_start is sampled.
- fill_done is high for exactly 1 clk, in the cycle fill_busy falls.
- Simultaneous fill_start and wr_valid in IDLE: the host write is accepted that cycle; the fill starts the next cycle.
- pix_en with bright_in low creates no slot, and pix_q is unchanged.

## Test plan
- Reset: hold clear=0 while toggling all inputs, then release -> every output is 0 until the first stimulus; wr_ready becomes 1 on the first clk after release.
- Host write with pix_en=0: write (x=3, y=2, rgb=5) -> in the accept cycle, mem_we=1, mem_addr=323, mem_wdata=5. Then write x=160 -> accepted with mem_we=0.
- Fill: fill_start with fill_rgb=6 and no pix_en -> 19200 consecutive writes at addresses 0..19199 with data 6; fill_done pulses once; wr_ready=0 throughout; a second fill_start sent mid-fill has no effect.
- Scan-out: RAM model preloaded with a ramp; pix_en every 2nd clk, bright_in=1, h_counter=8, v_counter=4 -> a read at address 162 in T+1; rgb equals the RAM word at T+3; sync outputs are delayed exactly 3 clk.
- Contention: continuous wr_valid during active video -> wr_ready drops only in display-slot cycles; no write coincides with a read; all writes eventually land.
- Reset mid-fill at fill_cnt=5000 -> fill_busy=0 immediately and no fill_done; a new fill_start then starts again from address 0.

Source files
------------

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port synchronous frame-buffer RAM between
// VGA scan-out reads, a host pixel-write port and a clear-screen fill engine.
// The frame buffer is 160x120 at 3 bits per pixel, and each buffer pixel
// covers a 4x4 block of screen pixels.
//
// Ports:
//   clk, clear            clock, asynchronous active-low reset
//   pix_en                one-cycle strobe per VGA pixel
//   h_counter, v_counter  VGA timer counters (valid with pix_en)
//   hsync_in, vsync_in,   timer syncs and display enable
//   bright_in
//   hsync, vsync, bright  syncs and enable delayed 3 clk to align with rgb
//   rgb                   pixel colour {R,G,B}; 0 while bright is low
//   mem_addr, mem_we,     RAM address, write enable and write data
//   mem_wdata
//   mem_rdata             RAM read data, valid one clk after the address
//   wr_valid, wr_ready    host write handshake (wr_ready is combinational)
//   wr_x, wr_y, wr_rgb    host write coordinate and colour
//   fill_start, fill_rgb  fill request pulse and fill colour
//   fill_busy, fill_done  fill active, one-cycle completion pulse
module vga_fb_arbiter #(
  localparam int unsigned FB_W   = 160,
  localparam int unsigned FB_H   = 120,
  localparam int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              pix_en,
  input  logic [9:0]        h_counter,
  input  logic [9:0]        v_counter,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              bright_in,
  output logic              hsync,
  output logic              vsync,
  output logic              bright,
  output logic [2:0]        rgb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [2:0]        mem_wdata,
  input  logic [2:0]        mem_rdata,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [2:0]        wr_rgb,
  input  logic              fill_start,
  input  logic [2:0]        fill_rgb,
  output logic              fill_busy,
  output logic              fill_done
);

  localparam int unsigned FILL_LAST = FB_W * FB_H - 1;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  // Linear address y*160 + x, built from shifts so no multiplier is needed.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [6:0] y,
                                                input logic [7:0] x);
    return (ADDR_W'(y) << 7) + (ADDR_W'(y) << 5) + ADDR_W'(x);
  endfunction

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [2:0]          fill_rgb_q, fill_rgb_d;
  logic                fill_done_q, fill_done_d;
  logic                fill_wr_c;

  logic                disp_req_q;
  logic [ADDR_W-1:0]   disp_addr_q;
  logic                rd_q;
  logic [2:0]          pix_q;
  logic [2:0]          hs_q, vs_q, br_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2:0]          wdata_q;
  logic                host_in_range_c;
  logic                slot_c;
  logic                unused_vbits;

  // Only v_counter[8:2] selects a buffer row.
  assign unused_vbits = ^{v_counter[9], v_counter[1:0]};

  // A display slot opens on the first screen pixel of each 4-pixel group.
  assign slot_c = pix_en && bright_in && (h_counter[1:0] == 2'b00);

  // Display request and read pipeline; pix_q holds between slots.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      disp_req_q  <= 1'b0;
      disp_addr_q <= '0;
      rd_q        <= 1'b0;
      pix_q       <= '0;
    end else begin
      disp_req_q <= slot_c;
      if (slot_c) disp_addr_q <= fb_addr(v_counter[8:2], h_counter[9:2]);
      rd_q <= disp_req_q;
      if (rd_q) pix_q <= mem_rdata;
    end
  end

  // Sync/enable delay line matching the 3-clk read pipeline.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      hs_q <= '0;
      vs_q <= '0;
      br_q <= '0;
    end else begin
      hs_q <= {hs_q[1:0], hsync_in};
      vs_q <= {vs_q[1:0], vsync_in};
      br_q <= {br_q[1:0], bright_in};
    end
  end

  assign hsync  = hs_q[2];
  assign vsync  = vs_q[2];
  assign bright = br_q[2];
  assign rgb    = bright ? pix_q : 3'b000;

  // Fill engine state register.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      fill_cnt_q  <= '0;
      fill_rgb_q  <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_rgb_q  <= fill_rgb_d;
      fill_done_q <= fill_done_d;
    end
  end

  // Fill engine next state: one write per cycle not taken by a display read.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    fill_rgb_d  = fill_rgb_q;
    fill_done_d = 1'b0;
    fill_wr_c   = 1'b0;
    if (state_q == IDLE) begin
      if (fill_start) begin
        state_d    = FILL;
        fill_cnt_d = '0;
        fill_rgb_d = fill_rgb;
      end
    end else begin
      if (!disp_req_q) begin
        fill_wr_c = 1'b1;
        if (fill_cnt_q == ADDR_W'(FILL_LAST)) begin
          state_d     = IDLE;
          fill_cnt_d  = '0;
          fill_done_d = 1'b1;
        end else begin
          fill_cnt_d = fill_cnt_q + ADDR_W'(1);
        end
      end
    end
  end

  assign fill_busy = (state_q == FILL);
  assign fill_done = fill_done_q;
  assign wr_ready  = clear && !disp_req_q && !fill_busy;

  assign host_in_range_c = (wr_x < 8'(FB_W)) && (wr_y < 7'(FB_H));

  // RAM port mux: display read, then fill, then host; otherwise hold.
  always_comb begin
    mem_addr  = addr_q;
    mem_we    = 1'b0;
    mem_wdata = wdata_q;
    if (disp_req_q) begin
      mem_addr = disp_addr_q;
    end else if (fill_wr_c) begin
      mem_addr  = fill_cnt_q;
      mem_we    = 1'b1;
      mem_wdata = fill_rgb_q;
    end else if (wr_valid && wr_ready && host_in_range_c) begin
      mem_addr  = fb_addr(wr_y, wr_x);
      mem_we    = 1'b1;
      mem_wdata = wr_rgb;
    end
  end

  // Remember the last presented address/data so idle cycles hold them.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

  localparam int NPIX = 160 * 120;

  logic        clk = 1'b0;
  logic        clear;
  logic        pix_en;
  logic [9:0]  h_counter, v_counter;
  logic        hsync_in, vsync_in, bright_in;
  logic        hsync, vsync, bright;
  logic [2:0]  rgb;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [2:0]  wr_rgb;
  logic        fill_start;
  logic [2:0]  fill_rgb;
  logic        fill_busy, fill_done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .clear(clear), .pix_en(pix_en),
    .h_counter(h_counter), .v_counter(v_counter),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .bright_in(bright_in),
    .hsync(hsync), .vsync(vsync), .bright(bright), .rgb(rgb),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .fill_start(fill_start), .fill_rgb(fill_rgb),
    .fill_busy(fill_busy), .fill_done(fill_done)
  );

  // Single-port synchronous RAM: data valid one clk after the address.
  logic [2:0] ram [0:32767];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference frame-buffer contents as the host/fill rules define them.
  logic [2:0] exp_fb [0:NPIX-1];

  typedef struct {
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
    logic        we;
    logic [14:0] addr;
    logic [2:0]  wdata;
  } vec_t;
  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pix_en = 0; h_counter = 0; v_counter = 0;
    hsync_in = 0; vsync_in = 0; bright_in = 0;
    wr_valid = 0; wr_x = 0; wr_y = 0; wr_rgb = 0;
    fill_start = 0; fill_rgb = 0;
  endtask

  task automatic host_write(input int x, input int y, input logic [2:0] c);
    wr_valid = 1; wr_x = 8'(x); wr_y = 7'(y); wr_rgb = c;
    @(negedge clk);
    check("preload_we", 32'(mem_we), 32'd1);
    exp_fb[y * 160 + x] = c;
    tick();
    wr_valid = 0;
  endtask

  // Random-phase model state
  logic        hs_h [4], vs_h [4], br_h [4];
  logic        rd_v [4];
  logic [2:0]  rd_d [4];
  logic [2:0]  pix_model;
  logic [14:0] last_addr;
  logic        slot_prev;
  int          slot_addr_prev;
  int          nw, nbusy, ndone, done_c, bad_addr, bad_ready, bad_done_busy, bad_ram;
  int          k, kold, kr, a;

  initial begin
    vecs[0] = '{8'd3,   7'd2,   3'd5, 1'b1, 15'd323,   3'd5};
    vecs[1] = '{8'd160, 7'd0,   3'd1, 1'b0, 15'd323,   3'd5};
    vecs[2] = '{8'd0,   7'd0,   3'd7, 1'b1, 15'd0,     3'd7};
    vecs[3] = '{8'd159, 7'd119, 3'd2, 1'b1, 15'd19199, 3'd2};
    vecs[4] = '{8'd10,  7'd120, 3'd3, 1'b0, 15'd19199, 3'd2};
    vecs[5] = '{8'd0,   7'd119, 3'd4, 1'b1, 15'd19040, 3'd4};

    // ---------------- reset with toggling inputs ----------------
    idle_inputs();
    clear = 0;
    for (int i = 0; i < 6; i++) begin
      pix_en = 1'($urandom); h_counter = 10'($urandom); v_counter = 10'($urandom);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom); bright_in = 1'($urandom);
      wr_valid = 1'($urandom); wr_x = 8'($urandom); wr_y = 7'($urandom);
      wr_rgb = 3'($urandom); fill_start = 1'($urandom); fill_rgb = 3'($urandom);
      @(negedge clk);
      check("reset_outputs", 32'({hsync, vsync, bright, rgb, mem_we, mem_addr,
                                  mem_wdata, fill_busy, fill_done, wr_ready}), 32'd0);
      tick();
    end
    idle_inputs();
    clear = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_reset_ready", 32'(wr_ready), 32'd1);
      check("post_reset_outputs", 32'({hsync, vsync, bright, rgb, mem_we, mem_addr,
                                       mem_wdata, fill_busy, fill_done}), 32'd0);
      tick();
    end

    // ---------------- host write table ----------------
    foreach (vecs[i]) begin
      wr_valid = 1; wr_x = vecs[i].x; wr_y = vecs[i].y; wr_rgb = vecs[i].c;
      @(negedge clk);
      check("host_ready", 32'(wr_ready), 32'd1);
      check("host_we", 32'(mem_we), 32'(vecs[i].we));
      check("host_addr", 32'(mem_addr), 32'(vecs[i].addr));
      check("host_wdata", 32'(mem_wdata), 32'(vecs[i].wdata));
      tick();
    end
    wr_valid = 0;
    tick();

    // ---------------- fill, with simultaneous host write ----------------
    fill_start = 1; fill_rgb = 3'd6;
    wr_valid = 1; wr_x = 8'd1; wr_y = 7'd0; wr_rgb = 3'd3;
    @(negedge clk);
    check("fill_start_host_we", 32'(mem_we), 32'd1);
    check("fill_start_host_addr", 32'(mem_addr), 32'd1);
    check("fill_start_busy", 32'(fill_busy), 32'd0);
    tick();
    fill_start = 0; wr_x = 8'd200;
    nw = 0; nbusy = 0; ndone = 0; done_c = -1;
    bad_addr = 0; bad_ready = 0; bad_done_busy = 0;
    for (int c = 0; c < 19300; c++) begin
      @(negedge clk);
      if (c == 0) check("fill_busy_rise", 32'(fill_busy), 32'd1);
      if (fill_busy) begin
        nbusy++;
        if (wr_ready) bad_ready++;
      end
      if (mem_we) begin
        if (mem_addr !== 15'(nw) || mem_wdata !== 3'd6) bad_addr++;
        nw++;
      end
      if (fill_done) begin
        ndone++;
        done_c = c;
        if (fill_busy) bad_done_busy++;
      end
      tick();
      fill_start = (c == 1000);
      fill_rgb   = (c == 1000) ? 3'd1 : 3'd6;
    end
    wr_valid = 0;
    check("fill_writes", 32'(nw), 32'(NPIX));
    check("fill_busy_cycles", 32'(nbusy), 32'(NPIX));
    check("fill_done_count", 32'(ndone), 32'd1);
    check("fill_done_cycle", 32'(done_c), 32'(NPIX));
    check("fill_addr_data", 32'(bad_addr), 32'd0);
    check("fill_ready_low", 32'(bad_ready), 32'd0);
    check("fill_done_busy_low", 32'(bad_done_busy), 32'd0);
    tick();
    bad_ram = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (ram[i] !== 3'd6) bad_ram++;
      exp_fb[i] = 3'd6;
    end
    check("fill_ram_content", 32'(bad_ram), 32'd0);

    // ---------------- scan-out sequence ----------------
    host_write(2, 1, 3'd5);   // address 162
    host_write(3, 1, 3'd2);   // address 163
    tick(); tick(); tick();
    pix_en = 1; bright_in = 1; hsync_in = 1; vsync_in = 1; h_counter = 10'd8; v_counter = 10'd4;
    @(negedge clk);
    check("scan_T_ready", 32'(wr_ready), 32'd1);
    tick();
    pix_en = 0; bright_in = 0; hsync_in = 0; vsync_in = 0;
    @(negedge clk);
    check("scan_T1_addr", 32'(mem_addr), 32'd162);
    check("scan_T1_we", 32'(mem_we), 32'd0);
    check("scan_T1_ready", 32'(wr_ready), 32'd0);
    tick();
    pix_en = 1; bright_in = 1; vsync_in = 1; h_counter = 10'd12; v_counter = 10'd4;
    @(negedge clk);
    check("scan_T2_ready", 32'(wr_ready), 32'd1);
    check("scan_T2_syncs", 32'({hsync, vsync, bright, rgb}), 32'd0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("scan_T3_rgb", 32'(rgb), 32'd5);
    check("scan_T3_syncs", 32'({hsync, vsync, bright}), 32'b111);
    check("scan_T3_addr", 32'(mem_addr), 32'd163);
    check("scan_T3_ready", 32'(wr_ready), 32'd0);
    tick();
    @(negedge clk);
    check("scan_T4_rgb", 32'(rgb), 32'd0);
    check("scan_T4_syncs", 32'({hsync, vsync, bright}), 32'b000);
    tick();
    @(negedge clk);
    check("scan_T5_rgb", 32'(rgb), 32'd2);
    check("scan_T5_syncs", 32'({hsync, vsync, bright}), 32'b011);
    tick();
    pix_en = 1; bright_in = 0; h_counter = 10'd0; v_counter = 10'd0;
    @(negedge clk);
    tick();
    pix_en = 0;
    @(negedge clk);
    check("dark_pix_no_slot", 32'(wr_ready), 32'd1);
    check("dark_pix_addr_hold", 32'(mem_addr), 32'd163);
    tick(); tick(); tick(); tick();

    // ---------------- randomized contention vs model ----------------
    for (int i = 0; i < 4; i++) begin
      hs_h[i] = 0; vs_h[i] = 0; br_h[i] = 0; rd_v[i] = 0; rd_d[i] = 0;
    end
    pix_model = 3'd2; last_addr = 15'd163; slot_prev = 0; slot_addr_prev = 0;
    for (int t = 0; t < 2500; t++) begin
      pix_en    = 1'($urandom_range(0, 1));
      bright_in = ($urandom_range(0, 3) != 0);
      h_counter = 10'($urandom_range(0, 639));
      v_counter = 10'($urandom_range(0, 479));
      hsync_in  = 1'($urandom_range(0, 1));
      vsync_in  = 1'($urandom_range(0, 1));
      wr_valid  = ($urandom_range(0, 3) != 0);
      wr_x      = 8'($urandom_range(0, 175));
      wr_y      = 7'($urandom_range(0, 127));
      wr_rgb    = 3'($urandom);
      k = t % 4; kold = (t + 1) % 4; kr = (t + 2) % 4;
      hs_h[k] = hsync_in; vs_h[k] = vsync_in; br_h[k] = bright_in;
      @(negedge clk);
      if (rd_v[kr]) pix_model = rd_d[kr];
      rd_v[k] = 0;
      check("rand_syncs", 32'({hsync, vsync, bright}), 32'({hs_h[kold], vs_h[kold], br_h[kold]}));
      check("rand_rgb", 32'(rgb), br_h[kold] ? 32'(pix_model) : 32'd0);
      if (slot_prev) begin
        check("rand_read", 32'({wr_ready, mem_we, mem_addr}), 32'(slot_addr_prev));
        rd_v[k] = 1;
        rd_d[k] = exp_fb[slot_addr_prev];
        last_addr = 15'(slot_addr_prev);
      end else begin
        check("rand_ready", 32'(wr_ready), 32'd1);
        if (wr_valid && wr_x < 8'd160 && wr_y < 7'd120) begin
          a = int'(wr_y) * 160 + int'(wr_x);
          check("rand_write", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 15'(a), wr_rgb}));
          exp_fb[a] = wr_rgb;
          last_addr = 15'(a);
        end else begin
          check("rand_idle", 32'({mem_we, mem_addr}), 32'({1'b0, last_addr}));
        end
      end
      slot_prev = pix_en && bright_in && (h_counter[1:0] == 2'b00);
      slot_addr_prev = int'(v_counter[8:2]) * 160 + int'(h_counter[9:2]);
      tick();
    end
    idle_inputs();
    tick(); tick();
    bad_ram = 0;
    for (int i = 0; i < NPIX; i++) if (ram[i] !== exp_fb[i]) bad_ram++;
    check("writes_landed", 32'(bad_ram), 32'd0);

    // ---------------- reset mid-fill ----------------
    fill_start = 1; fill_rgb = 3'd3;
    tick();
    fill_start = 0;
    nw = 0;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if (mem_we) nw++;
      if (nw == 5000) break;
      tick();
    end
    check("midfill_reached", 32'(nw), 32'd5000);
    tick();
    clear = 0;
    #1;
    check("midfill_busy_drop", 32'(fill_busy), 32'd0);
    check("midfill_reset_outs", 32'({wr_ready, mem_we, mem_addr, fill_done}), 32'd0);
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (fill_done) ndone++;
      tick();
    end
    clear = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (fill_done || fill_busy) ndone++;
      tick();
    end
    check("midfill_no_done", 32'(ndone), 32'd0);
    fill_start = 1; fill_rgb = 3'd4;
    tick();
    fill_start = 0;
    @(negedge clk);
    check("refill_busy", 32'(fill_busy), 32'd1);
    check("refill_first", 32'({mem_we, mem_addr, mem_wdata}), 32'({1'b1, 15'd0, 3'd4}));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
